dnn_input_feeder: RTL and testbench

- Upstream neighbour of the DNN top level. Accepts training samples from the host and streams them to the DNN, one block cycle per sample.
- Each sample is a word stream of activations plus a label index and an etapos. It is written into one bank of a ping-pong buffer.
- The sample then drives act0, ans0 (one-hot, chunked) and etapos0 in lock-step with the shared cycle_index.
- Host loading of sample k+1 overlaps DNN consumption of sample k.

---
 rtl/dnn_input_feeder.sv | 176 +++++++++++++++++
 tb/tb_dnn_input_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dnn_input_feeder.sv
// dnn_input_feeder: ping-pong sample buffer between the host and the DNN.
// The host fills one bank beat by beat while the other bank streams to the
// DNN in lock-step with the shared block-cycle counter (cycle_index).
// A bank issues only at the block boundary (cycle_index == cpc-1), and
// banks are always consumed in the order they were filled.
module dnn_input_feeder #(
  parameter int width_in = 8,
  parameter int n0       = 1024,
  parameter int nL       = 64,
  parameter int fo0      = 8,
  parameter int z0       = 128,
  parameter int zL       = 4,
  parameter int fiL      = 4,
  parameter int ec       = 2,
  parameter int eta_w    = 4,
  localparam int APC     = z0 / fo0,
  localparam int ABEATS  = n0 / APC,
  localparam int ANS_PC  = zL / fiL,
  localparam int ANBEATS = nL / ANS_PC,
  localparam int CPC     = ABEATS + ec,
  localparam int CI_W    = (CPC > 1) ? $clog2(CPC) : 1,
  localparam int AB_W    = (ABEATS > 1) ? $clog2(ABEATS) : 1,
  localparam int LB_W    = (nL > 1) ? $clog2(nL) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CI_W-1:0]         cycle_index,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [APC*width_in-1:0] wr_act,
  input  logic [LB_W-1:0]         wr_label,
  input  logic [eta_w-1:0]        wr_etapos,
  output logic [width_in-1:0]     act0 [APC],
  output logic [ANS_PC-1:0]       ans0,
  output logic [eta_w-1:0]        etapos0,
  output logic                    sample_active,
  output logic [15:0]             samples_fed,
  output logic [15:0]             underruns
);

  // Reject parameter sets whose chunking does not divide exactly or whose
  // one-hot answer needs more beats than a block cycle provides.
  if ((z0 % fo0 != 0) || (n0 % APC != 0) || (zL % fiL != 0) ||
      (nL % ANS_PC != 0) || (ANBEATS > CPC)) begin : g_illegal_params
    $fatal(1, "dnn_input_feeder: illegal parameter combination");
  end

  logic [APC*width_in-1:0] mem_q [2][ABEATS];

  logic [1:0]             full_q, full_d;
  logic                   wbank_q, wbank_d;
  logic                   rbank_q, rbank_d;
  logic                   first_q, first_d;
  logic                   active_q, active_d;
  logic [AB_W-1:0]        wcnt_q, wcnt_d;
  logic [LB_W-1:0]        label_q [2], label_d [2];
  logic [eta_w-1:0]       eta_q [2], eta_d [2];
  logic [width_in-1:0]    act_q [APC], act_d [APC];
  logic [ANS_PC-1:0]      ans_q, ans_d;
  logic [eta_w-1:0]       etapos_q, etapos_d;
  logic [15:0]            fed_q, fed_d;
  logic [15:0]            under_q, under_d;

  logic                   wr_fire, wr_last, issue_edge, cand, go;
  logic [CI_W-1:0]        nk;
  int                     nk_i;

  assign wr_ready   = !full_q[wbank_q];
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_last    = wr_fire && (wcnt_q == AB_W'(ABEATS - 1));
  assign issue_edge = (cycle_index == CI_W'(CPC - 1));
  // Before anything has issued, bank 0 is by definition the next in order.
  assign cand       = first_q ? 1'b0 : ~rbank_q;
  assign go         = full_q[cand];

  // Bank fill bookkeeping and the block-boundary issue decision.
  always_comb begin
    full_d   = full_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    first_d  = first_q;
    active_d = active_q;
    wcnt_d   = wcnt_q;
    label_d  = label_q;
    eta_d    = eta_q;
    fed_d    = fed_q;
    under_d  = under_q;
    if (wr_fire) begin
      wcnt_d = wcnt_q + AB_W'(1);
      if (wr_last) begin
        wcnt_d           = '0;
        full_d[wbank_q]  = 1'b1;
        label_d[wbank_q] = wr_label;
        eta_d[wbank_q]   = wr_etapos;
        wbank_d          = ~wbank_q;
      end
    end
    // Decision looks only at full_q, so a bank completing on this very edge
    // waits one block. The bank being written is never the one being freed.
    if (issue_edge) begin
      if (active_q) full_d[rbank_q] = 1'b0;
      if (go) begin
        rbank_d  = cand;
        active_d = 1'b1;
        first_d  = 1'b0;
        fed_d    = fed_q + 16'd1;
      end else begin
        active_d = 1'b0;
        if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
      end
    end
  end

  // Output register: load chunk k one edge ahead so it is present at cycle_index == k.
  always_comb begin
    nk       = issue_edge ? '0 : cycle_index + CI_W'(1);
    nk_i     = int'(nk);
    ans_d    = '0;
    etapos_d = active_d ? eta_q[rbank_d] : '0;
    for (int i = 0; i < APC; i++) begin
      act_d[i] = '0;
      if (active_d && nk_i < ABEATS)
        act_d[i] = mem_q[rbank_d][nk[AB_W-1:0]][i*width_in +: width_in];
    end
    for (int j = 0; j < ANS_PC; j++) begin
      ans_d[j] = active_d && (nk_i < ANBEATS) &&
                 (int'(label_q[rbank_d]) == nk_i * ANS_PC + j);
    end
  end

  // Activation storage; not reset, since the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wbank_q][wcnt_q] <= wr_act;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q   <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      first_q  <= 1'b1;
      active_q <= 1'b0;
      wcnt_q   <= '0;
      label_q  <= '{default: '0};
      eta_q    <= '{default: '0};
      act_q    <= '{default: '0};
      ans_q    <= '0;
      etapos_q <= '0;
      fed_q    <= '0;
      under_q  <= '0;
    end else begin
      full_q   <= full_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      first_q  <= first_d;
      active_q <= active_d;
      wcnt_q   <= wcnt_d;
      label_q  <= label_d;
      eta_q    <= eta_d;
      act_q    <= act_d;
      ans_q    <= ans_d;
      etapos_q <= etapos_d;
      fed_q    <= fed_d;
      under_q  <= under_d;
    end
  end

  assign act0          = act_q;
  assign ans0          = ans_q;
  assign etapos0       = etapos_q;
  assign sample_active = active_q;
  assign samples_fed   = fed_q;
  assign underruns     = under_q;

endmodule

// File: tb/tb_dnn_input_feeder.sv
// Directed bench for dnn_input_feeder with default parameters
// (16 activations per beat, 64 beats, 66-cycle block, 64 labels).
module tb_dnn_input_feeder;
  localparam int CPC    = 66;
  localparam int ABEATS = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [6:0]   cycle_index = '0;
  logic         wr_valid;
  logic         wr_ready;
  logic [127:0] wr_act;
  logic [5:0]   wr_label;
  logic [3:0]   wr_etapos;
  logic [7:0]   act0 [16];
  logic [0:0]   ans0;
  logic [3:0]   etapos0;
  logic         sample_active;
  logic [15:0]  samples_fed;
  logic [15:0]  underruns;
  logic [127:0] act_flat;

  int total = 0;
  int bad   = 0;

  dnn_input_feeder dut (
    .clk(clk), .reset(reset), .cycle_index(cycle_index),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_act(wr_act),
    .wr_label(wr_label), .wr_etapos(wr_etapos), .act0(act0), .ans0(ans0),
    .etapos0(etapos0), .sample_active(sample_active),
    .samples_fed(samples_fed), .underruns(underruns)
  );

  always #5 clk = ~clk;

  always_comb begin
    act_flat = '0;
    for (int i = 0; i < 16; i++) act_flat[i*8 +: 8] = act0[i];
  end

  // Shared block-cycle counter, advanced just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) cycle_index = '0;
    else cycle_index = (int'(cycle_index) == CPC - 1) ? 7'd0 : cycle_index + 7'd1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] chunk(input int c, input int base);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'((c + i + base) % 256);
    return v;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; skip idles that many edges first.
  task automatic write_beats(input int n, input int label, input int eta,
                             input int base, input int skip);
    bit ok;
    repeat (skip) align();
    for (int b = 0; b < n; b++) begin
      wr_valid  = 1'b1;
      wr_act    = chunk(b, base);
      wr_label  = 6'(label);
      wr_etapos = 4'(eta);
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
        @(negedge clk);
        ok = wr_ready;
        align();
      end
      if (!ok) begin
        chk("wr_ready_timeout", 0, 1);
        b = n;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_ci0();
    bit seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = (cycle_index == 7'd0);
    end
    if (!seen) chk("ci0_timeout", 0, 1);
  endtask

  // Entered at the falling edge with cycle_index == 0; ends at cycle_index == CPC-1.
  task automatic check_block(input bit act, input int base, input int label, input int eta);
    logic [127:0] e;
    for (int k = 0; k < CPC; k++) begin
      e = (act && k < ABEATS) ? chunk(k, base) : '0;
      chk($sformatf("act0_k%0d", k), act_flat, e);
      chk($sformatf("ans0_k%0d", k), 128'(ans0), 128'(act && label == k));
      chk($sformatf("etapos0_k%0d", k), 128'(etapos0), act ? 128'(eta) : '0);
      chk($sformatf("active_k%0d", k), 128'(sample_active), 128'(act));
      if (k < CPC - 1) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 128'(wr_ready), 1);
    chk("rst_active", 128'(sample_active), 0);
    chk("rst_fed", 128'(samples_fed), 0);
    chk("rst_under", 128'(underruns), 0);
    chk("rst_act0", act_flat, 0);
    chk("rst_etapos", 128'(etapos0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    wr_valid  = 1'b0;
    wr_act    = '0;
    wr_label  = '0;
    wr_etapos = '0;

    do_reset();

    // One sample written during block 0, streamed in block 1.
    align();
    write_beats(64, 37, 5, 0, 0);
    wait_ci0();
    check_block(1, 0, 37, 5);
    chk("t1_fed", 128'(samples_fed), 1);
    chk("t1_under", 128'(underruns), 0);

    // Continuous host stream of three samples.
    do_reset();
    align();
    fork
      begin
        write_beats(64, 3, 4, 10, 0);
        write_beats(64, 9, 6, 20, 0);
        write_beats(64, 60, 8, 30, 0);
      end
      begin
        wait_ci0();
        check_block(1, 10, 3, 4);
        chk("t2_ready_low", 128'(wr_ready), 0);
        wait_ci0();
        chk("t2_ready_back", 128'(wr_ready), 1);
        check_block(1, 20, 9, 6);
        wait_ci0();
        check_block(1, 30, 60, 8);
      end
    join
    chk("t2_fed", 128'(samples_fed), 3);
    chk("t2_under", 128'(underruns), 0);

    // Starvation for three blocks, then label 63 / etapos 9.
    wait_ci0();
    check_block(0, 0, 0, 0);
    wait_ci0();
    check_block(0, 0, 0, 0);
    wait_ci0();
    chk("t3_under", 128'(underruns), 3);
    align();
    write_beats(64, 63, 9, 40, 0);
    wait_ci0();
    check_block(1, 40, 63, 9);
    chk("t3_fed", 128'(samples_fed), 4);
    chk("t3_under_hold", 128'(underruns), 3);

    // Last beat lands on the issue edge: one starved block, then issue.
    wait_ci0();
    align();
    write_beats(64, 17, 2, 50, 1);
    wait_ci0();
    check_block(0, 0, 0, 0);
    chk("t4_under", 128'(underruns), 5);
    wait_ci0();
    check_block(1, 50, 17, 2);
    chk("t4_fed", 128'(samples_fed), 5);

    // Reset during a partial write; only the fresh label-0 sample issues.
    do_reset();
    align();
    write_beats(30, 55, 7, 70, 0);
    do_reset();
    align();
    write_beats(64, 0, 1, 60, 0);
    wait_ci0();
    check_block(1, 60, 0, 1);
    chk("t5_fed", 128'(samples_fed), 1);
    chk("t5_under", 128'(underruns), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
